// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signals of the shared memory port.
// The arbiter takes the master view. The core and memory take the slave view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;

    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;

    logic          m_req;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_done, d_rdata, d_done, m_req, m_wr, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_done, d_rdata, d_done, m_req, m_wr, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one variable-latency memory port, with bounded data priority.
// Defining MEM_ARB_TIMEOUT_EN makes the arbiter abort any access that is not acked within TIMEOUT wait cycles.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               busy,
    output logic               err
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          own_d_q, own_d_d;
    logic          m_req_q, m_req_d;
    logic          m_wr_q, m_wr_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          fetch_forced;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            own_d_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            own_d_q   <= own_d_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        own_d_d      = own_d_q;
        m_req_d      = m_req_q;
        m_wr_d       = m_wr_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        fetch_forced = bus.i_req && (starve_q == 4'(STARVE_LIMIT));
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
        err_d        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                tmo_d = '0;
`endif
                // Data wins unless fetch has already waited out STARVE_LIMIT data grants.
                if (bus.d_req && !fetch_forced) begin
                    state_d   = WAIT_D;
                    own_d_d   = 1'b1;
                    m_req_d   = 1'b1;
                    m_wr_d    = bus.d_wr;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    starve_d  = bus.i_req ? starve_q + 4'd1 : '0;
                end else if (bus.i_req) begin
                    state_d  = WAIT_I;
                    own_d_d  = 1'b0;
                    m_req_d  = 1'b1;
                    m_wr_d   = 1'b0;
                    m_addr_d = bus.i_addr;
                    starve_d = '0;
                end
            end
            WAIT_I, WAIT_D: begin
                if (bus.m_ack) begin
                    m_req_d = 1'b0;
                    state_d = DONE;
                    if (!m_wr_q) begin
                        if (state_q == WAIT_D) d_rdata_d = bus.m_rdata;
                        else                   i_rdata_d = bus.m_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    m_req_d = 1'b0;
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_wr    = m_wr_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_done  = (state_q == DONE) && !own_d_q;
    assign bus.d_done  = (state_q == DONE) && own_d_q;
    assign busy        = (state_q != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter, with a transaction-timeline reference model.
// Each grant is predicted from the priority rules and then laid out as a cycle window.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN  = 1'b1;
    localparam int TIMEOUT = 8;
    localparam int MAX_LAT = 10;
`else
    localparam bit TMO_EN  = 1'b0;
    localparam int TIMEOUT = 64;
    localparam int MAX_LAT = 4;
`endif
    localparam int STARVE_LIMIT = 4;
    localparam int SAT_START    = 300;
    localparam int SAT_END      = 500;
    localparam int RST_AFTER    = 550;
    localparam int N_CYC        = 1000;

    logic clk = 1'b0;
    logic rst;
    logic busy, err;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Requester state as driven by the bench
    bit          ireq_on, dreq_on, dwr;
    logic [31:0] iaddr, daddr, dwdata;

    // Current transaction: granted in cycle g, m_req high g+1..a_eff, done in a_eff+1
    bit          tx_act, tx_d, tx_wr, tx_tmo;
    logic [31:0] tx_addr, tx_wdata, tx_rdata;
    int          g, a, a_eff, free_at, starve;
    logic [31:0] exp_irdata, exp_drdata;
    bit          exp_mreq, exp_busy, exp_idone, exp_ddone, exp_err;

    bit sat_seen_i, rst_done, rst_pending;
    int dcount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".m_req"},   32'(bus.m_req),   32'd0);
        check({tag, ".m_wr"},    32'(bus.m_wr),    32'd0);
        check({tag, ".m_addr"},  bus.m_addr,       32'd0);
        check({tag, ".m_wdata"}, bus.m_wdata,      32'd0);
        check({tag, ".i_rdata"}, bus.i_rdata,      32'd0);
        check({tag, ".d_rdata"}, bus.d_rdata,      32'd0);
        check({tag, ".i_done"},  32'(bus.i_done),  32'd0);
        check({tag, ".d_done"},  32'(bus.d_done),  32'd0);
        check({tag, ".busy"},    32'(busy),        32'd0);
        check({tag, ".err"},     32'(err),         32'd0);
    endtask

    task automatic new_i();
        ireq_on = 1'b1; iaddr = $urandom;
        bus.i_req = 1'b1; bus.i_addr = iaddr;
    endtask

    task automatic drop_i();
        ireq_on = 1'b0; bus.i_req = 1'b0;
    endtask

    task automatic new_d();
        dreq_on = 1'b1; dwr = 1'($urandom_range(0, 1)); daddr = $urandom; dwdata = $urandom;
        bus.d_req = 1'b1; bus.d_wr = dwr; bus.d_addr = daddr; bus.d_wdata = dwdata;
    endtask

    task automatic drop_d();
        dreq_on = 1'b0; bus.d_req = 1'b0;
    endtask

    task automatic grant(input int c);
        int lat;
        if (dreq_on && !(ireq_on && starve == STARVE_LIMIT)) begin
            tx_d = 1'b1; tx_wr = dwr; tx_addr = daddr; tx_wdata = dwdata;
            starve = ireq_on ? starve + 1 : 0;
        end else begin
            tx_d = 1'b0; tx_wr = 1'b0; tx_addr = iaddr; tx_wdata = '0;
            starve = 0;
        end
        lat      = $urandom_range(1, MAX_LAT);
        tx_act   = 1'b1;
        g        = c;
        a        = c + lat;
        tx_tmo   = TMO_EN && (lat > TIMEOUT);
        a_eff    = tx_tmo ? c + TIMEOUT : a;
        free_at  = a_eff + 2;
        tx_rdata = $urandom;
    endtask

    task automatic step();
        int c;
        bit sat, done_now;
        c   = cyc;
        sat = (c >= SAT_START) && (c < SAT_END);
        if (tx_act && c >= free_at) begin
            tx_act = 1'b0;
            if (tx_d) begin
                if (sat || $urandom_range(0, 1) == 1) new_d(); else drop_d();
            end else begin
                if (sat || $urandom_range(0, 1) == 1) new_i(); else drop_i();
            end
        end
        if (!ireq_on && (sat || $urandom_range(0, 2) == 0)) new_i();
        if (!dreq_on && (sat || $urandom_range(0, 2) == 0)) new_d();

        exp_mreq  = tx_act && c > g && c <= a_eff;
        exp_busy  = tx_act && c > g && c <= a_eff + 1;
        done_now  = tx_act && c == a_eff + 1;
        exp_idone = done_now && !tx_d;
        exp_ddone = done_now && tx_d;
        exp_err   = done_now && tx_tmo;
        if (done_now && !tx_tmo && !tx_wr) begin
            if (tx_d) exp_drdata = tx_rdata; else exp_irdata = tx_rdata;
        end

        if (!tx_act && (ireq_on || dreq_on)) grant(c);

        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom;
        if (tx_act && c > g && c <= a_eff) begin
            if (!tx_tmo && c == a) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = tx_rdata;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            bus.m_ack = 1'b1;
        end

        // Post-grant changes on the data requester must not leak into the access
        if (tx_act && tx_d && c > g) begin
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_wr    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic model_reset();
        drop_i();
        drop_d();
        bus.m_ack  = 1'b0;
        tx_act     = 1'b0;
        free_at    = cyc + 1;
        starve     = 0;
        exp_irdata = '0;
        exp_drdata = '0;
        exp_mreq   = 1'b0;
        exp_busy   = 1'b0;
        exp_idone  = 1'b0;
        exp_ddone  = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic compare();
        check("m_req",   32'(bus.m_req),  32'(exp_mreq));
        check("busy",    32'(busy),       32'(exp_busy));
        check("i_done",  32'(bus.i_done), 32'(exp_idone));
        check("d_done",  32'(bus.d_done), 32'(exp_ddone));
        check("err",     32'(err),        32'(exp_err));
        check("i_rdata", bus.i_rdata,     exp_irdata);
        check("d_rdata", bus.d_rdata,     exp_drdata);
        if (exp_mreq) begin
            check("m_addr", bus.m_addr,     tx_addr);
            check("m_wr",   32'(bus.m_wr),  32'(tx_wr));
            if (tx_wr) check("m_wdata", bus.m_wdata, tx_wdata);
        end
        if (cyc >= SAT_START && cyc < SAT_END) begin
            if (bus.d_done) dcount++;
            if (bus.i_done) begin
                if (sat_seen_i) check("starve_run", 32'(dcount), 32'(STARVE_LIMIT));
                sat_seen_i = 1'b1;
                dcount     = 0;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_req   = 1'b0; bus.i_addr  = '0;
        bus.d_req   = 1'b0; bus.d_wr    = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ack   = 1'b0; bus.m_rdata = '0;
        ireq_on = 1'b0; dreq_on = 1'b0; tx_act = 1'b0;
        free_at = 0; starve = 0; exp_irdata = '0; exp_drdata = '0;
        rst_done = 1'b0; rst_pending = 1'b0; sat_seen_i = 1'b0; dcount = 0;
        #7;
        check_zero("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (;;) begin
            if (cyc == SAT_START) begin
                sat_seen_i = 1'b0;
                dcount     = 0;
            end
            step();
            if (!rst_done && cyc > RST_AFTER && tx_act && tx_d && cyc > g && cyc <= a_eff) begin
                #2 rst = 1'b1;
                #1 check_zero("rst_mid");
                model_reset();
                rst_done    = 1'b1;
                rst_pending = 1'b1;
            end
            @(negedge clk);
            compare();
            if (cyc == N_CYC) break;
            @(posedge clk);
            #1;
            cyc++;
            if (rst_pending) begin
                rst         = 1'b0;
                rst_pending = 1'b0;
            end
        end
        check("rst_hit", 32'(rst_done), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
